// File: rtl/fifo_lvl.sv
// Purpose: single-clock valid/ready FIFO, any DEPTH, with fill level, almost flags, flush and threshold gate.
// Latency: write to dout_valid is 1 cycle (REGOUT=0) or 2 cycles (REGOUT=1).
// Backpressure: din_ready drops when full and nothing leaves this cycle; dout side holds until taken.
module fifo_lvl #(
    parameter  int DIN       = 16,
    parameter  int DEPTH     = 64,
    parameter  int THRESHOLD = 0,
    parameter  int AFULL     = DEPTH - 1,
    parameter  int AEMPTY    = 1,
    parameter  int REGOUT    = 0,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    output logic           din_ready,
    input  logic           din_valid,
    input  logic [DIN-1:0] din_data,
    input  logic           dout_ready,
    output logic           dout_valid,
    output logic [DIN-1:0] dout_data,
    output logic [LW-1:0]  level,
    output logic           afull,
    output logic           aempty
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THR_L    = LW'(THRESHOLD);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY);
    localparam logic [PW-1:0] LAST_P   = PW'(DEPTH - 1);
    localparam logic          GATE_RST = (THRESHOLD == 0);

    logic [DIN-1:0] ram [DEPTH];
    logic [PW-1:0]  wp;
    logic [PW-1:0]  rp;
    logic [LW-1:0]  cnt;
    logic [LW-1:0]  cnt_next;
    logic           gate_open;
    logic           gate_next;
    logic           gate_valid;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           afull_r;
    logic           aempty_r;

    // Pointers run 0..DEPTH-1 and wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    assign full       = (cnt == DEPTH_L);
    assign empty      = (cnt == '0);
    assign gate_valid = ~empty & gate_open;

    // Accepting while full is fine when an entry leaves in the same cycle.
    assign din_ready  = ~flush & (~full | pop);
    assign push       = din_valid & din_ready;
    assign cnt_next   = cnt + LW'(push) - LW'(pop);

    assign level  = cnt;
    assign afull  = afull_r;
    assign aempty = aempty_r;

    // Hysteretic gate: opens at THRESHOLD, stays open until the RAM runs dry; opening wins ties.
    always_comb begin
        gate_next = gate_open;
        if (THRESHOLD == 0) begin
            gate_next = 1'b1;
        end else if (cnt_next >= THR_L) begin
            gate_next = 1'b1;
        end else if (cnt_next == '0) begin
            gate_next = 1'b0;
        end
    end

    generate
        if (REGOUT != 0) begin : g_regout
            logic           oreg_valid;
            logic [DIN-1:0] oreg_data;

            // Pull a RAM entry whenever the output register is free or being drained.
            assign pop        = gate_valid & (~oreg_valid | dout_ready);
            assign dout_valid = oreg_valid & ~flush;
            assign dout_data  = oreg_data;

            // Output register valid tracks the gated RAM head whenever it may advance.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    oreg_valid <= 1'b0;
                end else if (~oreg_valid | dout_ready) begin
                    oreg_valid <= gate_valid;
                end
            end

            // Output register data is not reset; it is only meaningful under oreg_valid.
            always_ff @(posedge clk) begin
                if (pop) begin
                    oreg_data <= ram[rp];
                end
            end
        end else begin : g_comb
            assign dout_valid = gate_valid & ~flush;
            assign dout_data  = ram[rp];
            assign pop        = dout_valid & dout_ready;
        end
    endgenerate

    // Storage write; RAM contents are never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ram[wp] <= din_data;
        end
    end

    // Pointers, occupancy, gate and flags; flush has the same register effect as reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            gate_open <= GATE_RST;
            afull_r   <= 1'b0;
            aempty_r  <= 1'b1;
        end else begin
            if (push) begin
                wp <= ptr_inc(wp);
            end
            if (pop) begin
                rp <= ptr_inc(rp);
            end
            cnt       <= cnt_next;
            gate_open <= gate_next;
            afull_r   <= (cnt_next >= AFULL_L);
            aempty_r  <= (cnt_next <= AEMPTY_L);
        end
    end

    // Occupancy must stay within 0..DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt <= DEPTH_L);
            assert (!(pop && empty));
            assert (!(push && full && !pop));
        end
    end

endmodule
